adc_spi_capture: RTL and testbench
==================================

Name: adc_spi_capture

Overview:
Downstream consumer of the periodic active-low startCapture strobe produced by the ADC trigger stage. Each accepted trigger runs one serial read of an external SPI-style ADC, then delivers a parallel sample with a one-cycle valid pulse to the fabric.
- Frame: CS-framed, 16 SCLK cycles, MSB first, 12 data bits.
- Outputs: sample, sample_valid, busy, overrun flag.

Parameters:
- HALF_TICKS, 2: clk cycles per SCLK half-period. Must be ≥1.
- NUM_BITS, 16: SCLK rising edges per frame.
- DATA_BITS, 12: LSBs of the frame kept as the sample. Must be ≤ NUM_BITS.
- QUIET_TICKS, 8: clk cycles after CS deasserts before a new trigger is accepted. Must be ≥1.

Ports:
- clk  in  1  system clock (40 MHz).
- reset  in  1  asynchronous, active-low reset.
- startCapture  in  1  active-low trigger, synchronous to clk. Its falling edge requests a capture.
- adc_sdata  in  1  serial data from the ADC.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles high.
- sample  out  DATA_BITS  last captured sample. Holds until the next capture completes.
- sample_valid  out  1  one-cycle pulse when sample updates.
- busy  out  1  high while not IDLE.
- overrun  out  1  one-cycle pulse when a trigger is dropped.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, busy=0, overrun=0.
  - State=IDLE, all counters 0.
  - Edge register prev_start=0, so a startCapture held low across reset release does not trigger. It must be seen high, then low.
- Trigger: cycle N where startCapture=0 and prev_start=1. prev_start<=startCapture every cycle, in all states.
- States: IDLE, SETUP, SHIFT, HOLD, QUIET. All outputs are registered.
- IDLE: on trigger:
  - adc_cs_n<=0, busy<=1, tick<=HALF_TICKS-1, bitcnt<=NUM_BITS-1, go to SETUP.
  - With trigger at cycle 0, cs_n low and busy are visible at cycle 1.
- SETUP: tick counts down. At tick==0: adc_sclk<=0, tick reload, go to SHIFT.
- SHIFT: at each tick==0, toggle adc_sclk and reload tick.
  - On a low→high toggle, shreg<={shreg[NUM_BITS-2:0], adc_sdata}, using adc_sdata as sampled in that cycle.
  - If bitcnt==0 on that rising toggle, go to HOLD (sclk stays high). Otherwise bitcnt--.
- HOLD: after HALF_TICKS cycles:
  - adc_cs_n<=1, sample<=shreg[DATA_BITS-1:0] (upper NUM_BITS-DATA_BITS bits discarded), sample_valid<=1.
  - tick<=QUIET_TICKS-1, go to QUIET.
- QUIET: tick counts down. At tick==0: busy<=0, go to IDLE.
- Timing, trigger at cycle 0, H=HALF_TICKS:
  - k-th SCLK rising edge visible at cycle 2kH+1.
  - cs_n high and sample_valid visible at cycle (2·NUM_BITS+1)H+1. Defaults: cycle 67.
  - busy falls at cycle 67+QUIET_TICKS (defaults: 75). The cycle-75 IDLE state accepts a trigger.
- Trigger in any non-IDLE state: ignored. overrun<=1 for one cycle. The current frame is unaffected.
- sample_valid and overrun are never held more than one cycle.
- Counter widths: tick is $clog2(max(HALF_TICKS,QUIET_TICKS)+1) bits, bitcnt is $clog2(NUM_BITS) bits. Counters never wrap below 0.

Decomposition:
- Package adc_cap_pkg: state enumeration (IDLE, SETUP, SHIFT, HOLD, QUIET) and default constants (HALF_TICKS, NUM_BITS, DATA_BITS, QUIET_TICKS, CLK_FREQ).
- One sub-module is natural: adc_trig_edge. It holds the prev_start register and produces a one-cycle trigger, with reset value 0.
- SCLK generation and the shifter stay in the top-level FSM.

Test Plan:
1. Reset asserted with startCapture=1, then released → all outputs at reset values. No activity for 200 cycles.
2. Defaults; ADC model shifts frame 0x0ABC on SCLK falling edges; startCapture falls at cycle 0 →
   - cs_n low during cycles 1–66; exactly 16 SCLK rising edges, at cycles 5, 9, …, 65.
   - sample=0xABC with a single sample_valid pulse at cycle 67.
   - busy low at cycle 75.
3. startCapture held low 100 cycles, as the trigger stage produces → exactly one frame and one sample_valid; overrun never asserts.
4. Second falling edge at cycle 30 → overrun pulses one cycle, no second frame. A new edge at cycle 80 starts a frame with cs_n low at 81.
5. Reset asserted at cycle 40 mid-SHIFT → cs_n=1 and sclk=1 immediately, no sample_valid. Release with startCapture low → no frame until a high→low edge.
6. Frames 0xFFFF then 0x0555 → sample=0xFFF then 0x555, each with exactly one sample_valid.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared states, default constants and helpers for the ADC capture block
package adc_cap_pkg;

  // Capture sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    QUIET = 3'd4
  } state_t;

  localparam int DEF_HALF_TICKS  = 2;
  localparam int DEF_NUM_BITS    = 16;
  localparam int DEF_DATA_BITS   = 12;
  localparam int DEF_QUIET_TICKS = 8;
  localparam int CLK_FREQ        = 40_000_000;

  // Larger of two integers, used to size the shared tick counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_trig_edge.sv
// rtl/adc_trig_edge.sv - falling-edge detector on the active-low startCapture strobe
module adc_trig_edge
  import adc_cap_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start_n,
  output logic o_trig
);

  logic r_prev;

  // Previous strobe level; resets to 0 so a strobe held low through reset never fires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_start_n;
    end
  end

  assign o_trig = r_prev & ~i_start_n;

endmodule

// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - trigger-driven serial ADC frame reader with parallel sample output
module adc_spi_capture
  import adc_cap_pkg::*;
#(
  parameter int HALF_TICKS  = DEF_HALF_TICKS,
  parameter int NUM_BITS    = DEF_NUM_BITS,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int QUIET_TICKS = DEF_QUIET_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startCapture,
  input  logic                 adc_sdata,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TICK_W = $clog2(max_int(HALF_TICKS, QUIET_TICKS) + 1);
  localparam int BIT_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [TICK_W-1:0] HALF_RELOAD  = TICK_W'(HALF_TICKS - 1);
  localparam logic [TICK_W-1:0] QUIET_RELOAD = TICK_W'(QUIET_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(NUM_BITS - 1);

  state_t                r_state;
  logic [TICK_W-1:0]     r_tick;
  logic [BIT_W-1:0]      r_bitcnt;
  // Only the kept LSBs are stored; the leading frame bits fall off the top
  logic [DATA_BITS-1:0]  r_shreg;
  logic                  r_cs_n;
  logic                  r_sclk;
  logic [DATA_BITS-1:0]  r_sample;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_overrun;

  state_t                w_state_nxt;
  logic [TICK_W-1:0]     w_tick_nxt;
  logic [BIT_W-1:0]      w_bitcnt_nxt;
  logic [DATA_BITS-1:0]  w_shreg_nxt;
  logic                  w_cs_n_nxt;
  logic                  w_sclk_nxt;
  logic [DATA_BITS-1:0]  w_sample_nxt;
  logic                  w_valid_nxt;
  logic                  w_busy_nxt;
  logic                  w_overrun_nxt;
  logic                  w_trig;

  adc_trig_edge u_trig_edge (
    .clk       (clk),
    .reset     (reset),
    .i_start_n (startCapture),
    .o_trig    (w_trig)
  );

  // State, counters and all outputs registered; reset parks the ADC bus idle at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_sample  <= w_sample_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Next-state logic: frame sequencing, SCLK toggling, shifting and pulse outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_bitcnt_nxt  = r_bitcnt;
    w_shreg_nxt   = r_shreg;
    w_cs_n_nxt    = r_cs_n;
    w_sclk_nxt    = r_sclk;
    w_sample_nxt  = r_sample;
    w_valid_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_overrun_nxt = w_trig && (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_cs_n_nxt   = 1'b0;
          w_busy_nxt   = 1'b1;
          w_tick_nxt   = HALF_RELOAD;
          w_bitcnt_nxt = BIT_LAST;
          w_state_nxt  = SETUP;
        end
      end
      SETUP: begin
        if (r_tick == '0) begin
          w_sclk_nxt  = 1'b0;
          w_tick_nxt  = HALF_RELOAD;
          w_state_nxt = SHIFT;
        end else begin
          w_tick_nxt = r_tick - TICK_W'(1);
        end
      end
      SHIFT: begin
        if (r_tick == '0) begin
          w_tick_nxt = HALF_RELOAD;
          if (!r_sclk) begin
            w_sclk_nxt  = 1'b1;
            w_shreg_nxt = {r_shreg[DATA_BITS-2:0], adc_sdata};
            if (r_bitcnt == '0) begin
              w_state_nxt = HOLD;
            end else begin
              w_bitcnt_nxt = r_bitcnt - BIT_W'(1);
            end
          end else begin
            w_sclk_nxt = 1'b0;
          end
        end else begin
          w_tick_nxt = r_tick - TICK_W'(1);
        end
      end
      HOLD: begin
        if (r_tick == '0) begin
          w_cs_n_nxt   = 1'b1;
          w_sample_nxt = r_shreg;
          w_valid_nxt  = 1'b1;
          w_tick_nxt   = QUIET_RELOAD;
          w_state_nxt  = QUIET;
        end else begin
          w_tick_nxt = r_tick - TICK_W'(1);
        end
      end
      QUIET: begin
        if (r_tick == '0) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_tick_nxt = r_tick - TICK_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign adc_cs_n     = r_cs_n;
  assign adc_sclk     = r_sclk;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb/tb_adc_spi_capture.sv - directed vector bench for adc_spi_capture
`timescale 1ns/1ps
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        startCapture;
  logic        adc_sdata = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  adc_spi_capture dut (
    .clk          (clk),
    .reset        (reset),
    .startCapture (startCapture),
    .adc_sdata    (adc_sdata),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ADC model: MSB appears on the first SCLK fall, next bit on each later fall
  logic [15:0] frame = 16'h0000;
  int          idx   = 15;
  always @(negedge adc_cs_n) idx = 15;
  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      adc_sdata = frame[idx];
      if (idx > 0) idx--;
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Per-cycle capture of DUT outputs
  logic        rec_cs   [0:199];
  logic        rec_sclk [0:199];
  logic        rec_sv   [0:199];
  logic        rec_ovr  [0:199];
  logic        rec_busy [0:199];
  logic [11:0] rec_smp  [0:199];

  // Strobe schedule: 0 = short low pulse, 1 = held low 100 cycles, 2 = retrigger at 30 and 80
  function automatic logic sched(input int mode, input int n);
    case (mode)
      0: return !(n < 2);
      1: return !(n < 100);
      2: return !((n < 2) || (n >= 30 && n < 32) || (n >= 80 && n < 82));
      default: return 1'b1;
    endcase
  endfunction

  // Index n is cycle n relative to the trigger cycle 0
  task automatic run_window(input int ncyc, input int mode);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      rec_cs[n]   = adc_cs_n;
      rec_sclk[n] = adc_sclk;
      rec_sv[n]   = sample_valid;
      rec_ovr[n]  = overrun;
      rec_busy[n] = busy;
      rec_smp[n]  = sample;
      startCapture = sched(mode, n);
    end
  endtask

  task automatic idle_cycles(input int k);
    startCapture = 1'b1;
    repeat (k) @(negedge clk);
  endtask

  int a_rises, a_first_rise, a_last_rise, a_rise_bad;
  int a_cs_low, a_cs_first, a_cs_falls, a_cs_fall2;
  int a_sv_cnt, a_sv_cyc, a_busy_fall, a_ovr_cnt, a_ovr_cyc;

  task automatic analyze(input int ncyc);
    a_rises = 0; a_first_rise = -1; a_last_rise = -1; a_rise_bad = 0;
    a_cs_low = 0; a_cs_first = -1; a_cs_falls = 0; a_cs_fall2 = -1;
    a_sv_cnt = 0; a_sv_cyc = -1; a_busy_fall = -1; a_ovr_cnt = 0; a_ovr_cyc = -1;
    for (int n = 1; n < ncyc; n++) begin
      if (!rec_sclk[n-1] && rec_sclk[n]) begin
        a_rises++;
        if (a_first_rise < 0) a_first_rise = n;
        a_last_rise = n;
        if (n != 4 * a_rises + 1) a_rise_bad++;
      end
      if (!rec_cs[n]) begin
        a_cs_low++;
        if (a_cs_first < 0) a_cs_first = n;
      end
      if (rec_cs[n-1] && !rec_cs[n]) begin
        a_cs_falls++;
        if (a_cs_falls == 2) a_cs_fall2 = n;
      end
      if (rec_sv[n]) begin
        a_sv_cnt++;
        if (a_sv_cyc < 0) a_sv_cyc = n;
      end
      if (rec_busy[n-1] && !rec_busy[n] && a_busy_fall < 0) a_busy_fall = n;
      if (rec_ovr[n]) begin
        a_ovr_cnt++;
        if (a_ovr_cyc < 0) a_ovr_cyc = n;
      end
    end
  endtask

  typedef struct {
    logic [15:0] frame;
    int          mode;
    logic [11:0] exp_sample;
  } vec_t;

  vec_t vecs[5];
  int   quiet_bad;

  initial begin
    vecs[0] = '{16'h0ABC, 0, 12'hABC};
    vecs[1] = '{16'h0ABC, 1, 12'hABC};
    vecs[2] = '{16'hFFFF, 0, 12'hFFF};
    vecs[3] = '{16'h0555, 0, 12'h555};
    vecs[4] = '{16'hF123, 0, 12'h123};

    // Reset with strobe high, then a long quiet stretch
    reset = 1'b0;
    startCapture = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    quiet_bad = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!adc_cs_n || !adc_sclk || busy || sample_valid || overrun) quiet_bad++;
    end
    chk("idle_activity", quiet_bad, 0);

    // Frame vectors
    for (int v = 0; v < 5; v++) begin
      idle_cycles(20);
      frame = vecs[v].frame;
      run_window(130, vecs[v].mode);
      analyze(130);
      chk($sformatf("v%0d_cs_first_low", v), a_cs_first, 1);
      chk($sformatf("v%0d_cs_low_cycles", v), a_cs_low, 66);
      chk($sformatf("v%0d_cs_falls", v), a_cs_falls, 1);
      chk($sformatf("v%0d_sclk_rises", v), a_rises, 16);
      chk($sformatf("v%0d_first_rise", v), a_first_rise, 5);
      chk($sformatf("v%0d_last_rise", v), a_last_rise, 65);
      chk($sformatf("v%0d_rise_spacing", v), a_rise_bad, 0);
      chk($sformatf("v%0d_valid_count", v), a_sv_cnt, 1);
      chk($sformatf("v%0d_valid_cycle", v), a_sv_cyc, 67);
      chk($sformatf("v%0d_sample", v), rec_smp[a_sv_cyc < 0 ? 129 : a_sv_cyc], vecs[v].exp_sample);
      chk($sformatf("v%0d_sample_hold", v), rec_smp[129], vecs[v].exp_sample);
      chk($sformatf("v%0d_busy_fall", v), a_busy_fall, 75);
      chk($sformatf("v%0d_overrun", v), a_ovr_cnt, 0);
    end

    // Retrigger while busy, then a legal trigger at cycle 80
    idle_cycles(20);
    frame = 16'h0321;
    run_window(130, 2);
    analyze(130);
    chk("ovr_count", a_ovr_cnt, 1);
    chk("ovr_cycle", a_ovr_cyc, 31);
    chk("ovr_valid_count", a_sv_cnt, 1);
    chk("ovr_sample", rec_smp[129], 12'h321);
    chk("ovr_cs_low_first", a_cs_low > 66 ? 66 : a_cs_low, 66);
    chk("ovr_second_frame_cs", a_cs_fall2, 81);
    idle_cycles(100);
    chk("ovr_second_sample", sample, 12'h321);

    // Reset mid-SHIFT with the strobe held low
    idle_cycles(20);
    frame = 16'h0ABC;
    run_window(41, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_cs_n", adc_cs_n, 1);
    chk("mid_rst_sclk", adc_sclk, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sample", sample, 0);
    chk("mid_rst_valid", sample_valid, 0);
    repeat (3) @(negedge clk);
    startCapture = 1'b0;
    reset = 1'b1;
    quiet_bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!adc_cs_n || busy || sample_valid || overrun) quiet_bad++;
    end
    chk("held_low_no_frame", quiet_bad, 0);
    idle_cycles(3);
    frame = 16'h0123;
    run_window(130, 0);
    analyze(130);
    chk("post_rst_cs_first", a_cs_first, 1);
    chk("post_rst_valid_count", a_sv_cnt, 1);
    chk("post_rst_sample", rec_smp[129], 12'h123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
